// File: rtl/ps2_mouse_ctrl_funcmod.sv
// ----------------------------------------------------------------------------
// ps2_mouse_ctrl_funcmod
//
// PS/2 mouse initialisation sequencer. It runs the IntelliMouse command script
// (FF, F3 C8, F3 64, F3 50, F2, F4) through the byte-level PS/2 write function
// and checks every device response that arrives through the read function.
// Each command is acknowledged with FA. The reset command (FF) is then
// followed by the BAT result AA and a device ID byte. The ID command (F2) is
// followed by the ID byte, which is captured.
//
// A resend request (FE), an unexpected byte or a timeout retries the current
// command. The same retry counter covers all three causes. When the counter is
// exhausted the script aborts into FAIL.
//
// Ports
//   CLOCK    in   system clock (50 MHz nominal)
//   RESET    in   asynchronous, active-low reset
//   START    in   one-cycle pulse; honoured only in IDLE, DONE or FAIL
//   WrEn     out  write request level, held until WrDone
//   WrData   out  command byte, stable while WrEn=1
//   WrDone   in   one-cycle pulse, write function finished the byte
//   RdDone   in   one-cycle pulse, read function received a byte
//   RdData   in   received byte, valid with RdDone
//   EnSig    out  streaming enabled (script completed)
//   MouseID  out  ID byte from the F2 response
//   IsWheel  out  MouseID == 8'h03
//   Busy     out  script in progress
//   Error    out  script aborted
//
// All outputs are registered. They are computed from the next state, so
// WrEn rises in the same cycle the state register enters SEND.
// ----------------------------------------------------------------------------
module ps2_mouse_ctrl_funcmod #(
    parameter logic [19:0] T_ACK     = 20'd1_000_000,
    parameter logic [24:0] T_BAT     = 25'd25_000_000,
    parameter logic [1:0]  MAX_RETRY = 2'd3
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    output logic       WrEn,
    output logic [7:0] WrData,
    input  logic       WrDone,
    input  logic       RdDone,
    input  logic [7:0] RdData,
    output logic       EnSig,
    output logic [7:0] MouseID,
    output logic       IsWheel,
    output logic       Busy,
    output logic       Error
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SEND       = 4'd1,
        ST_WAIT_ACK   = 4'd2,
        ST_WAIT_BAT   = 4'd3,
        ST_WAIT_BATID = 4'd4,
        ST_WAIT_ID    = 4'd5,
        ST_NEXT       = 4'd6,
        ST_DONE       = 4'd7,
        ST_FAIL       = 4'd8
    } state_t;

    localparam logic [3:0]  STEP_RESET = 4'd0;   // FF: expects FA, AA, id
    localparam logic [3:0]  STEP_GETID = 4'd7;   // F2: expects FA, id
    localparam logic [3:0]  STEP_LAST  = 4'd8;   // F4: enable streaming

    localparam logic [7:0]  RSP_ACK    = 8'hFA;
    localparam logic [7:0]  RSP_BAT_OK = 8'hAA;
    localparam logic [7:0]  ID_WHEEL   = 8'h03;

    // The timer counts from 0 on the first waiting cycle, so it hits LIMIT on
    // the T-th cycle spent waiting.
    localparam logic [24:0] ACK_LIMIT  = {5'd0, T_ACK} - 25'd1;
    localparam logic [24:0] BAT_LIMIT  = T_BAT - 25'd1;

    // Command script ROM.
    function automatic logic [7:0] script_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'hFF;   // reset
            4'd1:    b = 8'hF3;   // set sample rate
            4'd2:    b = 8'hC8;   //   200
            4'd3:    b = 8'hF3;
            4'd4:    b = 8'h64;   //   100
            4'd5:    b = 8'hF3;
            4'd6:    b = 8'h50;   //   80  (IntelliMouse magic knock)
            4'd7:    b = 8'hF2;   // get device ID
            4'd8:    b = 8'hF4;   // enable data reporting
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // True for the states in which the response timer runs.
    function automatic logic is_wait(input state_t s);
        logic w;
        case (s)
            ST_WAIT_ACK, ST_WAIT_BAT, ST_WAIT_BATID, ST_WAIT_ID: w = 1'b1;
            default:                                             w = 1'b0;
        endcase
        return w;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  step_r, step_s;
    logic [1:0]  retry_r, retry_s;
    logic [24:0] timer_r, timer_s;
    logic [7:0]  mouseid_r, mouseid_s;
    logic        iswheel_r, iswheel_s;
    logic        wren_r, wren_s;
    logic [7:0]  wrdata_r, wrdata_s;
    logic        ensig_r, ensig_s;
    logic        busy_r, busy_s;
    logic        error_r, error_s;

    logic        retry_req_s;
    logic        ack_timeout_s;
    logic        bat_timeout_s;

    assign ack_timeout_s = (timer_r == ACK_LIMIT);
    assign bat_timeout_s = (timer_r == BAT_LIMIT);

    // State register and all registered outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= ST_IDLE;
            step_r    <= 4'd0;
            retry_r   <= 2'd0;
            timer_r   <= 25'd0;
            mouseid_r <= 8'h00;
            iswheel_r <= 1'b0;
            wren_r    <= 1'b0;
            wrdata_r  <= 8'h00;
            ensig_r   <= 1'b0;
            busy_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            step_r    <= step_s;
            retry_r   <= retry_s;
            timer_r   <= timer_s;
            mouseid_r <= mouseid_s;
            iswheel_r <= iswheel_s;
            wren_r    <= wren_s;
            wrdata_r  <= wrdata_s;
            ensig_r   <= ensig_s;
            busy_r    <= busy_s;
            error_r   <= error_s;
        end
    end

    // Next-state logic: script sequencing, response checking, retry handling.
    always_comb begin
        state_s     = state_r;
        step_s      = step_r;
        retry_s     = retry_r;
        mouseid_s   = mouseid_r;
        iswheel_s   = iswheel_r;
        retry_req_s = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (START) begin
                    state_s = ST_SEND;
                    step_s  = 4'd0;
                    retry_s = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end

            // Bytes arriving while the write is still in flight are ignored.
            ST_SEND: begin
                if (WrDone) begin
                    state_s = ST_WAIT_ACK;
                end else begin
                    state_s = ST_SEND;
                end
            end

            // A byte in the timeout cycle is taken; the timeout loses.
            ST_WAIT_ACK: begin
                if (RdDone) begin
                    if (RdData == RSP_ACK) begin
                        if (step_r == STEP_RESET) begin
                            state_s = ST_WAIT_BAT;
                        end else if (step_r == STEP_GETID) begin
                            state_s = ST_WAIT_ID;
                        end else begin
                            state_s = ST_NEXT;
                        end
                    end else begin
                        // FE (resend) and any other byte share the counter.
                        retry_req_s = 1'b1;
                    end
                end else if (ack_timeout_s) begin
                    retry_req_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_ACK;
                end
            end

            // Self-test result; FC (or anything but AA) means BAT failed.
            ST_WAIT_BAT: begin
                if (RdDone) begin
                    if (RdData == RSP_BAT_OK) begin
                        state_s = ST_WAIT_BATID;
                    end else begin
                        retry_req_s = 1'b1;
                    end
                end else if (bat_timeout_s) begin
                    retry_req_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_BAT;
                end
            end

            // The ID byte sent after BAT is not needed; F2 reads it properly.
            ST_WAIT_BATID: begin
                if (RdDone) begin
                    state_s = ST_NEXT;
                end else if (ack_timeout_s) begin
                    retry_req_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_BATID;
                end
            end

            ST_WAIT_ID: begin
                if (RdDone) begin
                    mouseid_s = RdData;
                    iswheel_s = (RdData == ID_WHEEL);
                    state_s   = ST_NEXT;
                end else if (ack_timeout_s) begin
                    retry_req_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_ID;
                end
            end

            ST_NEXT: begin
                retry_s = 2'd0;
                if (step_r == STEP_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    step_s  = step_r + 4'd1;
                    state_s = ST_SEND;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Resend the same step, or give up once the budget is spent.
        if (retry_req_s) begin
            if (retry_r == MAX_RETRY) begin
                state_s = ST_FAIL;
            end else begin
                retry_s = retry_r + 2'd1;
                state_s = ST_SEND;
            end
        end else begin
            retry_s = retry_s;
        end
    end

    // Response timer: cleared whenever a wait state is entered or left.
    always_comb begin
        timer_s = 25'd0;
        if (is_wait(state_r) && (state_s == state_r)) begin
            timer_s = timer_r + 25'd1;
        end else begin
            timer_s = 25'd0;
        end
    end

    // Output decode from the next state, so outputs line up with the state.
    always_comb begin
        wren_s   = (state_s == ST_SEND);
        wrdata_s = 8'h00;
        if (wren_s) begin
            wrdata_s = script_byte(step_s);
        end else begin
            wrdata_s = 8'h00;
        end
        ensig_s = (state_s == ST_DONE);
        error_s = (state_s == ST_FAIL);
        case (state_s)
            ST_IDLE, ST_DONE, ST_FAIL: busy_s = 1'b0;
            default:                   busy_s = 1'b1;
        endcase
    end

    assign WrEn    = wren_r;
    assign WrData  = wrdata_r;
    assign EnSig   = ensig_r;
    assign MouseID = mouseid_r;
    assign IsWheel = iswheel_r;
    assign Busy    = busy_r;
    assign Error   = error_r;

endmodule

// File: tb/tb_ps2_mouse_ctrl_funcmod.sv
// ----------------------------------------------------------------------------
// Testbench for ps2_mouse_ctrl_funcmod.
// A reference model turns a per-attempt device behaviour plan into the
// expected command byte sequence and the final status. A device model plays
// that plan against the DUT. A monitor compares every new write with the
// expected byte queue. Short timeouts keep the run small.
// ----------------------------------------------------------------------------
module tb_ps2_mouse_ctrl_funcmod;

    localparam int TACK = 40;
    localparam int TBAT = 100;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic       WrDone = 1'b0;
    logic       RdDone = 1'b0;
    logic [7:0] RdData = 8'h00;
    logic       WrEn;
    logic [7:0] WrData;
    logic       EnSig;
    logic [7:0] MouseID;
    logic       IsWheel;
    logic       Busy;
    logic       Error;

    ps2_mouse_ctrl_funcmod #(
        .T_ACK(20'd40),
        .T_BAT(25'd100),
        .MAX_RETRY(2'd3)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START),
        .WrEn(WrEn), .WrData(WrData), .WrDone(WrDone),
        .RdDone(RdDone), .RdData(RdData),
        .EnSig(EnSig), .MouseID(MouseID), .IsWheel(IsWheel),
        .Busy(Busy), .Error(Error)
    );

    always #10 CLOCK = ~CLOCK;

    typedef enum logic [2:0] {B_OK, B_FE, B_BAD, B_SIL, B_BATFAIL, B_BATSIL} beh_t;

    localparam logic [7:0] SCRIPT [0:8] =
        '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};

    beh_t       plan[$];
    logic [7:0] exp_q[$];
    int         exp_steps[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_id = 8'h00;
    logic [7:0] scen_id = 8'h00;
    bit         exp_done;
    bit         exp_fail;
    bit         force_max = 1'b0;
    logic       wren_prev = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor: every new write request must match the next expected byte.
    always @(negedge CLOCK) begin
        if (WrEn && !wren_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wrdata_unexpected got %02h want none", WrData);
            end else begin
                mon_exp = exp_q.pop_front();
                if (WrData !== mon_exp) begin
                    errors++;
                    $display("FAIL wrdata got %02h want %02h", WrData, mon_exp);
                end
            end
        end
        wren_prev <= WrEn;
    end

    // Reference model: walk the script step by step, one plan entry per write.
    task automatic build_expect();
        int   step;
        int   retry;
        int   a;
        beh_t b;
        step = 0; retry = 0; a = 0;
        exp_steps.delete();
        exp_done = 1'b0;
        exp_fail = 1'b0;
        while (1) begin
            b = (a < plan.size()) ? plan[a] : B_OK;
            exp_q.push_back(SCRIPT[step]);
            exp_steps.push_back(step);
            a++;
            if (b == B_OK) begin
                if (step == 7) model_id = scen_id;
                retry = 0;
                if (step == 8) begin
                    exp_done = 1'b1;
                    break;
                end
                step++;
            end else if (retry == 3) begin
                exp_fail = 1'b1;
                break;
            end else begin
                retry++;
            end
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
    endtask

    function automatic int rdelay();
        if (force_max || ($urandom_range(0, 3) == 0)) return TACK;
        return int'($urandom_range(1, TACK));
    endfunction

    function automatic logic [7:0] bad_byte();
        logic [7:0] r;
        r = 8'($urandom);
        if (r == 8'hFA || r == 8'hFE) r = 8'h12;
        return r;
    endfunction

    // Byte arrives d cycles after the current negedge's following posedge.
    task automatic send_byte(int d, logic [7:0] b);
        repeat (d - 1) @(negedge CLOCK);
        RdDone = 1'b1;
        RdData = b;
        @(negedge CLOCK);
        RdDone = 1'b0;
    endtask

    task automatic wait_wren(output bit ok);
        int budget;
        budget = 0;
        while (!WrEn && budget < 4 * TBAT) begin
            @(negedge CLOCK);
            budget++;
        end
        ok = WrEn;
    endtask

    // Device model: serve n write attempts according to the plan.
    task automatic run_device(int n);
        bit   ok;
        beh_t b;
        int   st;
        for (int a = 0; a < n; a++) begin
            wait_wren(ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL wren_wait attempt %0d got 0 want 1", a);
                return;
            end
            b  = (a < plan.size()) ? plan[a] : B_OK;
            st = exp_steps[a];
            if (a == 1) pulse_start();          // START while sending: ignored
            tick($urandom_range(0, 3));
            WrDone = 1'b1;
            @(negedge CLOCK);
            WrDone = 1'b0;
            case (b)
                B_OK: begin
                    send_byte(rdelay(), 8'hFA);
                    if (st == 0) begin
                        send_byte(rdelay(), 8'hAA);
                        send_byte(rdelay(), 8'($urandom));
                    end else if (st == 7) begin
                        send_byte(rdelay(), scen_id);
                    end
                end
                B_FE:  send_byte(rdelay(), 8'hFE);
                B_BAD: send_byte(rdelay(), bad_byte());
                B_SIL: begin
                    tick(3);
                    pulse_start();              // START while waiting: ignored
                end
                B_BATFAIL: begin
                    if (st == 0) begin
                        send_byte(rdelay(), 8'hFA);
                        send_byte(rdelay(), 8'hFC);
                    end else begin
                        send_byte(rdelay(), bad_byte());
                    end
                end
                B_BATSIL: begin
                    if (st == 0) send_byte(rdelay(), 8'hFA);
                end
                default: ;
            endcase
        end
    endtask

    task automatic finish_scenario(string nm);
        int budget;
        budget = 0;
        while (Busy && budget < 8 * TBAT) begin
            @(negedge CLOCK);
            budget++;
        end
        tick(3);
        check({nm, ".busy"},    32'(Busy),    32'd0);
        check({nm, ".ensig"},   32'(EnSig),   32'(exp_done));
        check({nm, ".error"},   32'(Error),   32'(exp_fail));
        check({nm, ".mouseid"}, 32'(MouseID), 32'(model_id));
        check({nm, ".iswheel"}, 32'(IsWheel), 32'(model_id == 8'h03));
        check({nm, ".pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic scenario(string nm, logic [7:0] id);
        scen_id = id;
        build_expect();
        pulse_start();
        run_device(exp_steps.size());
        finish_scenario(nm);
    endtask

    task automatic check_all_zero(string nm);
        check({nm, ".wren"},    32'(WrEn),    32'd0);
        check({nm, ".wrdata"},  32'(WrData),  32'd0);
        check({nm, ".ensig"},   32'(EnSig),   32'd0);
        check({nm, ".mouseid"}, 32'(MouseID), 32'd0);
        check({nm, ".iswheel"}, 32'(IsWheel), 32'd0);
        check({nm, ".busy"},    32'(Busy),    32'd0);
        check({nm, ".error"},   32'(Error),   32'd0);
    endtask

    initial begin
        bit ok;
        int r;
        tick(3);
        check_all_zero("reset");
        RESET = 1'b1;
        tick(2);

        plan.delete();
        scenario("happy_wheel", 8'h03);
        scenario("plain_mouse", 8'h00);

        plan = '{B_OK, B_OK, B_FE};
        scenario("resend", 8'h03);

        plan = '{B_OK, B_SIL, B_SIL, B_SIL, B_SIL};
        scenario("timeout", 8'h03);

        plan.delete();
        scenario("rerun_after_fail", 8'h03);

        plan = '{B_BATFAIL};
        scenario("bat_fail", 8'h00);

        plan = '{B_BATSIL};
        scenario("bat_timeout", 8'h03);

        force_max = 1'b1;
        plan.delete();
        scenario("rd_on_timeout", 8'h03);
        force_max = 1'b0;

        // Reset while the step-4 command is being written.
        plan.delete();
        scen_id = 8'h03;
        build_expect();
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        pulse_start();
        run_device(4);
        wait_wren(ok);
        check("rst_mid.reached_step4", 32'(ok), 32'd1);
        #2 RESET = 1'b0;
        #1;
        check_all_zero("rst_mid");
        check("rst_mid.pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_id = 8'h00;
        @(negedge CLOCK);
        RESET = 1'b1;
        tick(2);
        plan.delete();
        scenario("after_reset", 8'h00);

        // Randomised behaviour plans.
        for (int s = 0; s < 15; s++) begin
            plan.delete();
            for (int k = 0; k < 14; k++) begin
                r = int'($urandom_range(0, 99));
                if (r < 70)      plan.push_back(B_OK);
                else if (r < 78) plan.push_back(B_FE);
                else if (r < 85) plan.push_back(B_BAD);
                else if (r < 92) plan.push_back(B_SIL);
                else if (r < 96) plan.push_back(B_BATFAIL);
                else             plan.push_back(B_BATSIL);
            end
            r = int'($urandom_range(0, 2));
            scenario("random", (r == 0) ? 8'h03 : (r == 1) ? 8'h00 : 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
